magnetron_power_ctrl: RTL and testbench

- Next-generation magnetron on/off controller. Replaces the combinational set/reset decode with a registered cook state machine.
- Adds selectable power levels via slot-based duty cycling, pause/resume, two-press stop-to-cancel, and an end-of-cook beep.
- Sits between the front-panel button/door inputs and the magnetron driver and timer blocks.

---
 rtl/magnetron_power_ctrl.sv | 145 ++++++++++++++
 tb/tb_magnetron_power_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/magnetron_power_ctrl.sv
// Registered cook state machine for the magnetron: press detection, slot-based
// duty cycling of the power level, pause/resume, stop-to-cancel and end beep.
`timescale 1ns/1ps
module magnetron_power_ctrl #(
  parameter int LEVEL_W     = 3,
  parameter int SLOT_CYCLES = 4,
  parameter int BEEP_CYCLES = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               startn,
  input  logic               stopn,
  input  logic               clearn,
  input  logic               door_closed,
  input  logic               timer_done,
  input  logic [LEVEL_W-1:0] power_level,
  output logic               mag_on,
  output logic               timer_en,
  output logic               timer_clear,
  output logic               beep,
  output logic [1:0]         state
);

  localparam int MAX_LEVEL = (1 << LEVEL_W) - 1;
  localparam int SC_W      = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int BC_W      = $clog2(BEEP_CYCLES + 1);

  localparam logic [SC_W-1:0]    SLOT_LAST = SC_W'(SLOT_CYCLES - 1);
  localparam logic [LEVEL_W-1:0] IDX_LAST  = LEVEL_W'(MAX_LEVEL - 1);
  localparam logic [BC_W-1:0]    BEEP_LOAD = BC_W'(BEEP_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COOK  = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [SC_W-1:0]    slot_cnt_q, slot_cnt_d;
  logic [LEVEL_W-1:0] slot_idx_q, slot_idx_d;
  logic [BC_W-1:0]    beep_cnt_q, beep_cnt_d;
  logic               timer_clear_d;
  logic               start_h, stop_h, clear_h;
  logic               start_press, stop_press, clear_press;

  // A press is a high-to-low step of the active-low button between two edges.
  assign start_press = start_h & ~startn;
  assign stop_press  = stop_h  & ~stopn;
  assign clear_press = clear_h & ~clearn;

  always_comb begin
    state_d       = state_q;
    level_d       = level_q;
    slot_cnt_d    = slot_cnt_q;
    slot_idx_d    = slot_idx_q;
    beep_cnt_d    = beep_cnt_q;
    timer_clear_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_press) begin
          timer_clear_d = 1'b1;
        end else if (start_press && door_closed && (power_level != '0) && !timer_done) begin
          state_d    = COOK;
          level_d    = power_level;
          slot_cnt_d = '0;
          slot_idx_d = '0;
        end
      end
      COOK: begin
        if (clear_press) begin
          state_d       = IDLE;
          timer_clear_d = 1'b1;
          slot_cnt_d    = '0;
          slot_idx_d    = '0;
        end else if (timer_done) begin
          state_d    = DONE;
          beep_cnt_d = BEEP_LOAD;
        end else if (!door_closed || stop_press) begin
          state_d = PAUSE;
        end else if (slot_cnt_q == SLOT_LAST) begin
          slot_cnt_d = '0;
          slot_idx_d = (slot_idx_q == IDX_LAST) ? '0 : slot_idx_q + 1'b1;
        end else begin
          slot_cnt_d = slot_cnt_q + 1'b1;
        end
      end
      PAUSE: begin
        // Counters hold here so a resume continues mid-period.
        if (clear_press || stop_press) begin
          state_d       = IDLE;
          timer_clear_d = 1'b1;
          slot_cnt_d    = '0;
          slot_idx_d    = '0;
        end else if (start_press && door_closed) begin
          state_d = COOK;
        end
      end
      DONE: begin
        if (clear_press || stop_press || start_press || !door_closed ||
            (beep_cnt_q <= BC_W'(1))) begin
          state_d       = IDLE;
          timer_clear_d = 1'b1;
          beep_cnt_d    = '0;
          slot_cnt_d    = '0;
          slot_idx_d    = '0;
        end else begin
          beep_cnt_d = beep_cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      level_q     <= '0;
      slot_cnt_q  <= '0;
      slot_idx_q  <= '0;
      beep_cnt_q  <= '0;
      timer_clear <= 1'b0;
      start_h     <= 1'b1;
      stop_h      <= 1'b1;
      clear_h     <= 1'b1;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      slot_cnt_q  <= slot_cnt_d;
      slot_idx_q  <= slot_idx_d;
      beep_cnt_q  <= beep_cnt_d;
      timer_clear <= timer_clear_d;
      start_h     <= startn;
      stop_h      <= stopn;
      clear_h     <= clearn;
    end
  end

  assign state    = state_q;
  assign mag_on   = (state_q == COOK) && (slot_idx_q < level_q);
  assign timer_en = (state_q == COOK);
  assign beep     = (state_q == DONE) && (beep_cnt_q != '0);

endmodule

// File: tb/tb_magnetron_power_ctrl.sv
// Directed bench for magnetron_power_ctrl: a vector table for single-edge
// behaviour plus hand sequences for duty, resume, beep, hold and async reset.
`timescale 1ns/1ps
module tb_magnetron_power_ctrl;

  logic       clk = 1'b0;
  logic       resetn, startn, stopn, clearn, door_closed, timer_done;
  logic [2:0] power_level;
  logic       mag_on, timer_en, timer_clear, beep;
  logic [1:0] state;

  int vec_count = 0;
  int err_count = 0;

  typedef struct {
    logic       s, p, c, d, t;
    logic [2:0] pl;
    logic [1:0] st;
    logic       mag, en, tc, bp;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  magnetron_power_ctrl #(.LEVEL_W(3), .SLOT_CYCLES(4), .BEEP_CYCLES(16)) dut (
    .clk(clk), .resetn(resetn), .startn(startn), .stopn(stopn), .clearn(clearn),
    .door_closed(door_closed), .timer_done(timer_done), .power_level(power_level),
    .mag_on(mag_on), .timer_en(timer_en), .timer_clear(timer_clear), .beep(beep),
    .state(state)
  );

  function automatic vec_t mkVec(input logic s, p, c, d, t, input logic [2:0] pl,
                                 input logic [1:0] st, input logic mag, en, tc, bp);
    vec_t v;
    v.s = s; v.p = p; v.c = c; v.d = d; v.t = t; v.pl = pl;
    v.st = st; v.mag = mag; v.en = en; v.tc = tc; v.bp = bp;
    return v;
  endfunction

  // Inputs change 1 ns after a rising edge; outputs are sampled there too.
  task automatic applyStimulus(input logic s, p, c, d, t, input logic [2:0] pl);
    startn = s; stopn = p; clearn = c; door_closed = d; timer_done = t; power_level = pl;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [1:0] es,
                             input logic em, ee, etc, eb);
    vec_count++;
    if (state !== es || mag_on !== em || timer_en !== ee || timer_clear !== etc || beep !== eb) begin
      err_count++;
      $display("[TB] FAIL %s: got state=%0d mag_on=%b timer_en=%b timer_clear=%b beep=%b, expected state=%0d mag_on=%b timer_en=%b timer_clear=%b beep=%b",
               name, state, mag_on, timer_en, timer_clear, beep, es, em, ee, etc, eb);
    end
  endtask

  task automatic checkCount(input string name, input int got, input int expv);
    vec_count++;
    if (got != expv) begin
      err_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, expv);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int nbeep;
    int trans;
    logic [1:0] prev;

    //                  s  p  c  d  t  pl   st  mag en tc bp
    vecs.push_back(mkVec(1, 1, 1, 1, 0, 3, 0, 0, 0, 0, 0)); // idle
    vecs.push_back(mkVec(0, 1, 1, 0, 0, 3, 0, 0, 0, 0, 0)); // start, door open
    vecs.push_back(mkVec(1, 1, 1, 1, 0, 3, 0, 0, 0, 0, 0));
    vecs.push_back(mkVec(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0)); // start, level 0
    vecs.push_back(mkVec(1, 1, 1, 1, 0, 3, 0, 0, 0, 0, 0));
    vecs.push_back(mkVec(0, 1, 1, 1, 1, 3, 0, 0, 0, 0, 0)); // start, timer_done
    vecs.push_back(mkVec(1, 1, 1, 1, 0, 3, 0, 0, 0, 0, 0));
    vecs.push_back(mkVec(1, 1, 0, 1, 0, 3, 0, 0, 0, 1, 0)); // clear in idle
    vecs.push_back(mkVec(1, 1, 1, 1, 0, 3, 0, 0, 0, 0, 0));
    vecs.push_back(mkVec(0, 1, 1, 1, 0, 3, 1, 1, 1, 0, 0)); // valid start
    vecs.push_back(mkVec(0, 1, 1, 1, 0, 0, 1, 1, 1, 0, 0)); // held start
    vecs.push_back(mkVec(1, 0, 1, 1, 0, 0, 2, 0, 0, 0, 0)); // stop -> pause
    vecs.push_back(mkVec(1, 1, 1, 1, 0, 0, 2, 0, 0, 0, 0));
    vecs.push_back(mkVec(1, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0)); // second stop cancels
    vecs.push_back(mkVec(1, 1, 1, 1, 0, 7, 0, 0, 0, 0, 0));
    vecs.push_back(mkVec(0, 1, 1, 1, 0, 7, 1, 1, 1, 0, 0));
    vecs.push_back(mkVec(1, 1, 0, 1, 1, 7, 0, 0, 0, 1, 0)); // clear beats timer_done
    vecs.push_back(mkVec(1, 1, 1, 1, 0, 7, 0, 0, 0, 0, 0));
    vecs.push_back(mkVec(0, 1, 1, 1, 0, 7, 1, 1, 1, 0, 0));
    vecs.push_back(mkVec(1, 1, 1, 0, 0, 7, 2, 0, 0, 0, 0)); // door open -> pause
    vecs.push_back(mkVec(1, 1, 1, 1, 0, 7, 2, 0, 0, 0, 0)); // door closed, no press
    vecs.push_back(mkVec(0, 1, 1, 1, 0, 7, 1, 1, 1, 0, 0)); // resume
    vecs.push_back(mkVec(1, 1, 1, 1, 1, 7, 3, 0, 0, 0, 1)); // timer_done -> done
    vecs.push_back(mkVec(1, 1, 1, 1, 1, 7, 3, 0, 0, 0, 1));
    vecs.push_back(mkVec(1, 0, 1, 1, 0, 7, 0, 0, 0, 1, 0)); // stop during beep
    vecs.push_back(mkVec(1, 1, 1, 1, 0, 7, 0, 0, 0, 0, 0));

    resetn = 1'b0; startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
    door_closed = 1'b1; timer_done = 1'b0; power_level = 3'd3;
    #3;
    checkOutput("reset", 2'd0, 0, 0, 0, 0);
    #4 resetn = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].s, vecs[i].p, vecs[i].c, vecs[i].d, vecs[i].t, vecs[i].pl);
      checkOutput($sformatf("vec%0d", i), vecs[i].st, vecs[i].mag, vecs[i].en, vecs[i].tc, vecs[i].bp);
    end

    // Level 3: 12 cycles on, 16 off, period 28.
    applyStimulus(0, 1, 1, 1, 0, 3);
    checkOutput("duty k0", 2'd1, 1, 1, 0, 0);
    for (int k = 1; k < 56; k++) begin
      applyStimulus(1, 1, 1, 1, 0, 3);
      checkOutput($sformatf("duty k%0d", k), 2'd1, ((k % 28) < 12), 1, 0, 0);
    end
    applyStimulus(1, 0, 1, 1, 0, 3);
    checkOutput("duty stop1", 2'd2, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 1, 0, 3);
    checkOutput("duty hold", 2'd2, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 1, 0, 3);
    checkOutput("duty stop2", 2'd0, 0, 0, 1, 0);
    applyStimulus(1, 1, 1, 1, 0, 3);
    checkOutput("duty tc end", 2'd0, 0, 0, 0, 0);

    // Pause at slot_idx=2, slot_cnt=2 and resume mid-slot: two more on cycles.
    applyStimulus(0, 1, 1, 1, 0, 3);
    for (int k = 1; k <= 10; k++) applyStimulus(1, 1, 1, 1, 0, 3);
    applyStimulus(1, 1, 1, 0, 0, 3);
    checkOutput("resume door open", 2'd2, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 1, 0, 3);
    applyStimulus(1, 1, 1, 1, 0, 3);
    checkOutput("resume no press", 2'd2, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 1, 0, 3);
    checkOutput("resume cnt2", 2'd1, 1, 1, 0, 0);
    applyStimulus(1, 1, 1, 1, 0, 3);
    checkOutput("resume cnt3", 2'd1, 1, 1, 0, 0);
    applyStimulus(1, 1, 1, 1, 0, 3);
    checkOutput("resume idx3", 2'd1, 0, 1, 0, 0);
    applyStimulus(1, 1, 0, 1, 0, 3);
    checkOutput("resume clear", 2'd0, 0, 0, 1, 0);
    applyStimulus(1, 1, 1, 1, 0, 3);

    // Full beep: 16 cycles high, then IDLE with one timer_clear pulse.
    applyStimulus(0, 1, 1, 1, 0, 5);
    applyStimulus(1, 1, 1, 1, 1, 5);
    checkOutput("beep enter", 2'd3, 0, 0, 0, 1);
    nbeep = (beep === 1'b1) ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1, 1, 1, 1, 0, 5);
      if (state != 2'd3) break;
      if (beep === 1'b1) nbeep++;
    end
    checkCount("beep length", nbeep, 16);
    checkOutput("beep end", 2'd0, 0, 0, 1, 0);
    applyStimulus(1, 1, 1, 1, 0, 5);
    checkOutput("beep end+1", 2'd0, 0, 0, 0, 0);

    // Stop press during the fifth beep cycle.
    applyStimulus(0, 1, 1, 1, 0, 5);
    applyStimulus(1, 1, 1, 1, 1, 5);
    for (int i = 2; i <= 5; i++) begin
      applyStimulus(1, 1, 1, 1, 0, 5);
      checkOutput($sformatf("beep cyc%0d", i), 2'd3, 0, 0, 0, 1);
    end
    applyStimulus(1, 0, 1, 1, 0, 5);
    checkOutput("beep stop", 2'd0, 0, 0, 1, 0);
    applyStimulus(1, 1, 1, 1, 0, 5);

    // Start held low for 20 cycles gives exactly one transition.
    prev = state;
    trans = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 1, 1, 1, 0, 7);
      if (state != prev) trans++;
      prev = state;
    end
    checkCount("held start transitions", trans, 1);
    checkOutput("held start state", 2'd1, 1, 1, 0, 0);

    // Asynchronous reset mid-cook, checked before the next rising edge.
    applyStimulus(1, 1, 1, 1, 0, 7);
    checkOutput("pre-reset cook", 2'd1, 1, 1, 0, 0);
    #3 resetn = 1'b0;
    #1;
    checkOutput("async reset", 2'd0, 0, 0, 0, 0);
    #2 resetn = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("after reset edge", 2'd0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
